stopwatch_ctrl: RTL and testbench

Button front-end and run-control FSM that sits directly upstream of the stopwatch counter/display block. It synchronises and debounces three raw push-buttons and turns them into clean press events. A four-state FSM drives the stopwatch's run-enable level, a one-cycle clear pulse and a lap-hold (display freeze) level.

---
 rtl/stopwatch_ctrl_if.sv | 35 +++
 rtl/stopwatch_ctrl.sv | 167 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Button/control bundle between the stopwatch front-end and its neighbours.
//
// Signals:
//   btn_start, btn_clear, btn_lap : raw active-high push-buttons (async levels)
//   run      : count-enable level to the stopwatch counter
//   clear    : one-cycle synchronous clear pulse to the stopwatch counter
//   lap_hold : high while the display shows a frozen lap value
//   state    : current run-control FSM state (debug LEDs)
//
// Handshake: there is no valid/ready pair on this bundle. Buttons are
// free-running levels with no timing relation to the clock; run, lap_hold
// and state are registered levels; clear is a registered single-cycle pulse
// that the consumer must act on in the cycle it is seen, with no back-pressure.
//
// Modports: master = side that owns the buttons and consumes the controls,
//           slave  = the stopwatch_ctrl block itself.
interface stopwatch_ctrl_if;
  logic       btn_start;
  logic       btn_clear;
  logic       btn_lap;
  logic       run;
  logic       clear;
  logic       lap_hold;
  logic [1:0] state;

  modport master (
    output btn_start, btn_clear, btn_lap,
    input  run, clear, lap_hold, state
  );

  modport slave (
    input  btn_start, btn_clear, btn_lap,
    output run, clear, lap_hold, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch button front-end and run-control FSM.
//
// Each raw button is passed through a 2-flop synchroniser, debounced by a
// per-button stable-level/counter pair, and turned into a one-cycle press
// event on the rising edge of the debounced level. A four-state FSM
// (IDLE/RUN/PAUSE/LAP) consumes the press events and drives registered
// run, clear and lap_hold outputs.
//
// Ports:
//   clock : system clock, all logic on its rising edge
//   reset : asynchronous active-low reset
//   sw    : stopwatch_ctrl_if.slave (buttons in; run/clear/lap_hold/state out)
//
// Parameters:
//   DEB_CYCLES : consecutive stable cycles needed to accept a new button level
//   DEB_W      : debounce counter width, 2**DEB_W must exceed DEB_CYCLES
module stopwatch_ctrl #(
  parameter int DEB_CYCLES = 1000000,
  parameter int DEB_W      = 20
) (
  input  logic             clock,
  input  logic             reset,
  stopwatch_ctrl_if.slave  sw
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  // Bit positions of the three buttons in the packed vectors below.
  localparam int B_START = 0;
  localparam int B_CLEAR = 1;
  localparam int B_LAP   = 2;

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [2:0]       raw;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       stable;
  logic [2:0]       stable_q;
  logic [2:0]       press;
  logic [DEB_W-1:0] cnt [3];

  state_t state_q;
  state_t next_state;
  logic   clear_q;
  logic   next_clear;
  logic   run_q;
  logic   lap_hold_q;

  assign raw = {sw.btn_lap, sw.btn_clear, sw.btn_start};

  // Two-flop synchroniser for all three buttons.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: the counter tracks how many consecutive cycles the synchronised
  // input has disagreed with the stable level. Any agreement restarts it, so
  // only DEB_CYCLES uninterrupted disagreeing cycles flip the stable level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stable <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= ~stable[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // Registered rising-edge detect: one press event per accepted press,
  // nothing on release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stable_q <= '0;
      press    <= '0;
    end else begin
      stable_q <= stable;
      press    <= stable & ~stable_q;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      clear_q    <= 1'b0;
      run_q      <= 1'b0;
      lap_hold_q <= 1'b0;
    end else begin
      state_q    <= next_state;
      clear_q    <= next_clear;
      run_q      <= (next_state == RUN) || (next_state == LAP);
      lap_hold_q <= (next_state == LAP);
    end
  end

  // Next-state logic. Priority is clear > start > lap, and the first event
  // that is meaningful in the current state wins; the others are dropped.
  // Clear is only honoured when not counting. Gating the pulse with clear_q
  // keeps it from ever stretching over two cycles.
  always_comb begin
    next_state = state_q;
    next_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press[B_CLEAR]) begin
          next_state = IDLE;
          next_clear = ~clear_q;
        end else if (press[B_START]) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (press[B_START]) begin
          next_state = PAUSE;
        end else if (press[B_LAP]) begin
          next_state = LAP;
        end
      end
      LAP: begin
        if (press[B_START]) begin
          next_state = PAUSE;
        end else if (press[B_LAP]) begin
          next_state = RUN;
        end
      end
      PAUSE: begin
        if (press[B_CLEAR]) begin
          next_state = IDLE;
          next_clear = ~clear_q;
        end else if (press[B_START]) begin
          next_state = RUN;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign sw.run      = run_q;
  assign sw.clear    = clear_q;
  assign sw.lap_hold = lap_hold_q;
  assign sw.state    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl with DEB_CYCLES=4, DEB_W=3.
// A behavioural reference model runs alongside the DUT: it keeps a short
// history of raw button samples, accepts a new level once the synchronised
// window is uniformly different, delays the resulting press event through
// the pipeline, and applies the state transition table directly.
module tb_stopwatch_ctrl;

  localparam int DEB = 4;
  localparam int HW  = DEB + 2;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int checks   = 0;
  int failures = 0;

  stopwatch_ctrl_if sw ();

  stopwatch_ctrl #(
    .DEB_CYCLES (DEB),
    .DEB_W      (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .sw    (sw.slave)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- observed vector ----------------
  logic [4:0] obs;
  assign obs = {sw.run, sw.clear, sw.lap_hold, sw.state};

  // ---------------- reference model ----------------
  // Button index: 0 = start, 1 = clear, 2 = lap.
  logic [HW-1:0] m_hist [3];
  logic [2:0]    m_s;
  logic [2:0]    m_rose_d1;
  logic [2:0]    m_rose_d2;
  logic [1:0]    m_state;
  logic          m_clear;
  logic [4:0]    m_exp;

  assign m_exp = {(m_state == 2'd1) || (m_state == 2'd3), m_clear,
                  (m_state == 2'd3), m_state};

  initial begin
    logic [2:0]     raw_now;
    logic [2:0]     rose_now;
    logic [2:0]     ev;
    logic [DEB-1:0] win;
    logic           new_s;
    logic           was_clear;
    for (int b = 0; b < 3; b++) m_hist[b] = '0;
    m_s = '0; m_rose_d1 = '0; m_rose_d2 = '0; m_state = 2'd0; m_clear = 1'b0;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        for (int b = 0; b < 3; b++) m_hist[b] = '0;
        m_s = '0; m_rose_d1 = '0; m_rose_d2 = '0; m_state = 2'd0; m_clear = 1'b0;
      end else begin
        // Event reaching the FSM now was accepted two cycles ago.
        ev        = m_rose_d2;
        m_rose_d2 = m_rose_d1;
        raw_now   = {sw.btn_lap, sw.btn_clear, sw.btn_start};
        for (int b = 0; b < 3; b++) begin
          m_hist[b] = {m_hist[b][HW-2:0], raw_now[b]};
          win       = m_hist[b][HW-1:2];
          new_s     = m_s[b];
          if (m_s[b] ? (win == '0) : (win == '1)) new_s = ~m_s[b];
          rose_now[b] = new_s & ~m_s[b];
          m_s[b]      = new_s;
        end
        m_rose_d1 = rose_now;
        was_clear = m_clear;
        m_clear   = 1'b0;
        if (ev[1] && (m_state == 2'd0 || m_state == 2'd2)) begin
          m_state = 2'd0;
          m_clear = !was_clear;
        end else if (ev[0]) begin
          m_state = (m_state == 2'd1 || m_state == 2'd3) ? 2'd2 : 2'd1;
        end else if (ev[2] && m_state == 2'd1) begin
          m_state = 2'd3;
        end else if (ev[2] && m_state == 2'd3) begin
          m_state = 2'd1;
        end
      end
    end
  end

  // ---------------- clear pulse monitor ----------------
  int   clear_count  = 0;
  int   clear_consec = 0;
  logic clear_prev   = 1'b0;

  initial begin
    forever begin
      @(negedge clock);
      if (sw.clear === 1'b1) begin
        clear_count++;
        if (clear_prev) clear_consec++;
      end
      clear_prev = (sw.clear === 1'b1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       sw.btn_start = v;
      1:       sw.btn_clear = v;
      default: sw.btn_lap   = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    tick(8);
    set_btn(b, 1'b0);
    tick(12);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sw.btn_start = 1'($urandom_range(0, 1));
      sw.btn_clear = 1'($urandom_range(0, 1));
      sw.btn_lap   = 1'($urandom_range(0, 1));
      tick(1);
      checks++;
      if (obs !== 5'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, obs, 5'b0);
      end
    end
    sw.btn_start = 1'b0; sw.btn_clear = 1'b0; sw.btn_lap = 1'b0;
    tick(1);
    reset = 1'b1;
    clear_count = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      checks++;
      if (obs !== 5'b0 || obs !== m_exp) begin
        failures++;
        $display("FAIL reset_release cyc=%0d got=%b exp=%b", i, obs, 5'b0);
      end
    end
    checks++;
    if (clear_count != 0) begin
      failures++;
      $display("FAIL reset_no_clear got=%0d exp=0", clear_count);
    end
  endtask

  task automatic test_start_stop();
    sw.btn_start = 1'b1;
    tick(7);
    checks++;
    if (sw.state !== 2'b00 || sw.run !== 1'b0) begin
      failures++;
      $display("FAIL start_latency_early got=%b exp=00 run=0", sw.state);
    end
    tick(1);
    checks++;
    if (sw.state !== 2'b01 || sw.run !== 1'b1) begin
      failures++;
      $display("FAIL start_latency got=%b/%b exp=01/1", sw.state, sw.run);
    end
    tick(12);
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 2'b01} || obs !== m_exp) begin
      failures++;
      $display("FAIL start_held got=%b exp=%b", obs, 5'b10001);
    end
    sw.btn_start = 1'b0;
    tick(12);
    press(0);
    checks++;
    if (obs !== {1'b0, 1'b0, 1'b0, 2'b10} || obs !== m_exp) begin
      failures++;
      $display("FAIL stop got=%b exp=%b", obs, 5'b00010);
    end
  endtask

  task automatic test_debounce();
    logic [6:0] pat;
    sw.btn_start = 1'b1;
    tick(3);
    sw.btn_start = 1'b0;
    tick(12);
    checks++;
    if (sw.state !== 2'b10 || obs !== m_exp) begin
      failures++;
      $display("FAIL glitch got=%b exp=10", sw.state);
    end
    pat = 7'b1111101;  // applied LSB first: 1,0,1,1,1,1,1
    for (int i = 0; i < 7; i++) begin
      sw.btn_start = pat[i];
      tick(1);
    end
    sw.btn_start = 1'b0;
    tick(2);
    checks++;
    if (sw.state !== 2'b10) begin
      failures++;
      $display("FAIL bounce_early got=%b exp=10", sw.state);
    end
    tick(1);
    checks++;
    if (sw.state !== 2'b01) begin
      failures++;
      $display("FAIL bounce_accept got=%b exp=01", sw.state);
    end
    tick(15);
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 2'b01} || obs !== m_exp) begin
      failures++;
      $display("FAIL bounce_single got=%b exp=%b", obs, 5'b10001);
    end
  endtask

  task automatic test_lap();
    press(2);
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b1, 2'b11} || obs !== m_exp) begin
      failures++;
      $display("FAIL lap_enter got=%b exp=%b", obs, 5'b10111);
    end
    press(2);
    checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 2'b01} || obs !== m_exp) begin
      failures++;
      $display("FAIL lap_exit got=%b exp=%b", obs, 5'b10001);
    end
    press(2);
    press(0);
    checks++;
    if (obs !== {1'b0, 1'b0, 1'b0, 2'b10} || obs !== m_exp) begin
      failures++;
      $display("FAIL lap_start got=%b exp=%b", obs, 5'b00010);
    end
  endtask

  task automatic test_clear();
    press(0);
    clear_count = 0;
    press(1);
    checks++;
    if (sw.state !== 2'b01 || clear_count != 0 || obs !== m_exp) begin
      failures++;
      $display("FAIL clear_in_run got=%b pulses=%0d exp=01 pulses=0", sw.state, clear_count);
    end
    press(0);
    clear_count = 0;
    sw.btn_clear = 1'b1;
    tick(8);
    checks++;
    if (sw.clear !== 1'b1 || sw.state !== 2'b00) begin
      failures++;
      $display("FAIL clear_pulse got=%b/%b exp=1/00", sw.clear, sw.state);
    end
    tick(1);
    checks++;
    if (sw.clear !== 1'b0) begin
      failures++;
      $display("FAIL clear_width got=%b exp=0", sw.clear);
    end
    tick(7);
    sw.btn_clear = 1'b0;
    tick(12);
    checks++;
    if (clear_count != 1 || obs !== 5'b0 || obs !== m_exp) begin
      failures++;
      $display("FAIL clear_once got=%0d/%b exp=1/%b", clear_count, obs, 5'b0);
    end
  endtask

  task automatic test_simultaneous();
    press(0);
    press(0);
    checks++;
    if (sw.state !== 2'b10) begin
      failures++;
      $display("FAIL simul_setup got=%b exp=10", sw.state);
    end
    clear_count = 0;
    sw.btn_clear = 1'b1;
    sw.btn_start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      checks++;
      if (sw.run !== 1'b0 || obs !== m_exp) begin
        failures++;
        $display("FAIL simul_run cyc=%0d got=%b exp=%b", i, obs, m_exp);
      end
    end
    sw.btn_clear = 1'b0;
    sw.btn_start = 1'b0;
    tick(12);
    checks++;
    if (sw.state !== 2'b00 || clear_count != 1) begin
      failures++;
      $display("FAIL simul_clear got=%b pulses=%0d exp=00 pulses=1", sw.state, clear_count);
    end
  endtask

  task automatic test_reset_mid();
    sw.btn_start = 1'b1;
    tick(4);
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== 5'b0) begin
      failures++;
      $display("FAIL reset_async got=%b exp=%b", obs, 5'b0);
    end
    sw.btn_start = 1'b0;
    tick(2);
    reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      checks++;
      if (obs !== 5'b0 || obs !== m_exp) begin
        failures++;
        $display("FAIL reset_mid cyc=%0d got=%b exp=%b", i, obs, 5'b0);
      end
    end
  endtask

  task automatic test_random();
    int hold [3];
    for (int b = 0; b < 3; b++) hold[b] = 0;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold[b] == 0) begin
          set_btn(b, 1'($urandom_range(0, 1)));
          hold[b] = $urandom_range(1, 10);
        end else begin
          hold[b]--;
        end
      end
      tick(1);
      checks++;
      if (obs !== m_exp) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b exp=%b", i, obs, m_exp);
      end
    end
    sw.btn_start = 1'b0; sw.btn_clear = 1'b0; sw.btn_lap = 1'b0;
    tick(20);
    checks++;
    if (obs !== m_exp) begin
      failures++;
      $display("FAIL random_settle got=%b exp=%b", obs, m_exp);
    end
    checks++;
    if (clear_consec != 0) begin
      failures++;
      $display("FAIL clear_back_to_back got=%0d exp=0", clear_consec);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    sw.btn_start = 1'b0;
    sw.btn_clear = 1'b0;
    sw.btn_lap   = 1'b0;
    #2;
    test_reset();
    test_start_stop();
    test_debounce();
    test_lap();
    test_clear();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
